imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, registered successor to the decode-stage immediate extender.
- Accepts instruction bits [31:7], a 3-bit immediate type and a sideband tag (PC), and produces an XLEN-wide immediate one cycle later.
- Sits between fetch/decode and the ID/EX register. Uses a valid/ready handshake with a 2-entry skid buffer so that backpressure never loses an instruction.
- Supports RV32/RV64 widths, flush, and deterministic zero output for non-immediate types.

Parameters:
- XLEN, 32, immediate output width. Legal values are 32 or 64; any other value is an elaboration error.
- TAG_W, 32, width of the sideband tag carried alongside each instruction.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  block can accept this cycle
- in_inst  in  25  instruction bits [31:7]
- in_type  in  3  immediate type, using the shared type macros (ITYPE, RTYPE, STYPE, BTYPE, UTYPE, JTYPE, CSRTYPE)
- in_tag  in  TAG_W  sideband (PC)
- out_valid  out  1  immediate valid
- out_ready  in  1  downstream accepts
- out_imm  out  XLEN  extended immediate
- out_type  out  3  type echoed alongside the immediate
- out_tag  out  TAG_W  tag echoed alongside the immediate

Behaviour:
- Extension is combinational on the input side and registered on capture.
- s = in_inst[31]. "sx" means sign-extend to XLEN using s.
- ITYPE: sx(inst[31:20]).
- STYPE: sx({inst[31:25], inst[11:7]}).
- BTYPE: sx({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
- UTYPE: sx({inst[31:12], 12'b0}). For XLEN=64, bits 63:32 are copies of bit 31 (RV64 LUI semantics).
- JTYPE: sx({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
- CSRTYPE: zero-extend inst[19:15].
- RTYPE and any undefined code: all zeros. X is never driven.
- Storage: a main output register (out_*) plus one skid register.
- in_ready = ~skid_valid & ~rst.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Accept when the main register is empty or being drained: the data loads into main. out_valid is 1 on the next edge. Latency is exactly 1 cycle.
- Accept while main holds and is not draining: the data loads into skid.
- Drain while skid is valid: skid moves into main on that edge and skid_valid clears. in_ready returns to 1 on the following cycle.
- Simultaneous accept and drain with skid empty: main reloads with the new data and out_valid stays 1, sustaining throughput of 1 per cycle.
- Main register contents are stable while out_valid=1 and out_ready=0.
- flush: on that edge out_valid and skid_valid both clear. An accept in the same cycle is discarded. Data registers may keep stale values. flush has priority over all other updates.
- Reset (asynchronous, at any time including mid-transfer):
  - out_valid=0, skid_valid=0, out_imm=0, out_type=0, out_tag=0.
  - in_ready=0 while rst is high, 1 on the first cycle after release.
- No combinational path from in_* to out_*. in_ready depends only on state and rst, never on out_ready.

Test Plan:
- ITYPE, inst 0xFFF00093 (addi x1,x0,-1), i.e. in_inst = inst[31:7], out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF; with XLEN=64, 0xFFFFFFFFFFFFFFFF.
- BTYPE 0xFE000EE3 → 0xFFFFFFFC. JTYPE 0x0010006F → 0x00000800. CSRTYPE inst with bits[19:15]=5'h1F → 0x0000001F. RTYPE → 0x0.
- UTYPE 0x800000B7, XLEN=64 → 0xFFFFFFFF80000000; with XLEN=32 → 0x80000000.
- Backpressure:
  - Hold out_ready=0 and send tags A, B, C back-to-back.
  - A stays in main; B goes to skid; in_ready=0, so C is not accepted.
  - Raise out_ready: outputs appear as A then B, each exactly once, in order.
  - C is accepted once in_ready=1.
- flush with main and skid both full and in_valid=1 on the same cycle → next cycle out_valid=0, in_ready=1, and no later output carries any of the three tags.
- Assert rst asynchronously mid-stream (between edges) → out_valid, out_imm, out_tag are 0 immediately. After release, the first accepted instruction emerges with 1-cycle latency.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate extender with a 2-entry skid buffer.
// Captures instruction bits [31:7], an immediate type and a sideband tag.
// Produces the XLEN-wide immediate one cycle after the instruction is accepted.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A producer holds valid and its payload until that transfer. in_ready
// depends only on state and rst, never on out_ready. out_* stays stable while
// out_valid=1 and out_ready=0.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      in_inst,
  input  logic [2:0]       in_type,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag
);

  // Shared immediate type encodings; codes not listed here produce zero.
  localparam logic [2:0] RTYPE   = 3'd0;
  localparam logic [2:0] ITYPE   = 3'd1;
  localparam logic [2:0] STYPE   = 3'd2;
  localparam logic [2:0] BTYPE   = 3'd3;
  localparam logic [2:0] UTYPE   = 3'd4;
  localparam logic [2:0] JTYPE   = 3'd5;
  localparam logic [2:0] CSRTYPE = 3'd6;

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  // Renumber the incoming bits so the slices below read like the ISA manual.
  logic [31:7] inst;
  logic        s;
  assign inst = in_inst;
  assign s    = inst[31];

  logic [XLEN-1:0] ext_imm;

  // Combinational extension on the input side; RTYPE and unknown codes give 0.
  always_comb begin
    ext_imm = '0;
    unique case (in_type)
      ITYPE:   ext_imm = {{(XLEN-12){s}}, inst[31:20]};
      STYPE:   ext_imm = {{(XLEN-12){s}}, inst[31:25], inst[11:7]};
      BTYPE:   ext_imm = {{(XLEN-12){s}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      UTYPE:   ext_imm = {{(XLEN-31){s}}, inst[30:12], 12'b0};
      JTYPE:   ext_imm = {{(XLEN-20){s}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      CSRTYPE: ext_imm = {{(XLEN-5){1'b0}}, inst[19:15]};
      RTYPE:   ext_imm = '0;
      default: ext_imm = '0;
    endcase
  end

  // Main (output) register and skid register.
  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [2:0]       main_type_q,  main_type_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [2:0]       skid_type_q,  skid_type_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

  logic accept;
  logic drain;

  assign in_ready  = ~skid_valid_q & ~rst;
  assign accept    = in_valid & in_ready;
  assign drain     = main_valid_q & out_ready;

  assign out_valid = main_valid_q;
  assign out_imm   = main_imm_q;
  assign out_type  = main_type_q;
  assign out_tag   = main_tag_q;

  // Next-state selection; flush wins, then skid refill, then direct load.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_type_d  = main_type_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_type_d  = skid_type_q;
    skid_tag_d   = skid_tag_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain && skid_valid_q) begin
      // in_ready is low while the skid holds data, so no accept can collide.
      main_imm_d   = skid_imm_q;
      main_type_d  = skid_type_q;
      main_tag_d   = skid_tag_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || drain)) begin
      main_valid_d = 1'b1;
      main_imm_d   = ext_imm;
      main_type_d  = in_type;
      main_tag_d   = in_tag;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = ext_imm;
      skid_type_d  = in_type;
      skid_tag_d   = in_tag;
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end

  // State register with asynchronous reset clearing valids and payloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_type_q  <= '0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_type_q  <= '0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_type_q  <= main_type_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_type_q  <= skid_type_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus.
module tb_imm_gen_pipe;

  localparam int W = 99;  // {imm64, type, tag}

  localparam logic [2:0] RTYPE   = 3'd0;
  localparam logic [2:0] ITYPE   = 3'd1;
  localparam logic [2:0] STYPE   = 3'd2;
  localparam logic [2:0] BTYPE   = 3'd3;
  localparam logic [2:0] UTYPE   = 3'd4;
  localparam logic [2:0] JTYPE   = 3'd5;
  localparam logic [2:0] CSRTYPE = 3'd6;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [24:0] in_inst;
  logic [2:0]  in_type;
  logic [31:0] in_tag;
  logic        out_ready;
  logic [63:0] drv_exp;

  logic        in_ready32, in_ready64;
  logic        out_valid32, out_valid64;
  logic [31:0] out_imm32;
  logic [63:0] out_imm64;
  logic [2:0]  out_type32, out_type64;
  logic [31:0] out_tag32, out_tag64;

  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_type(out_type32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_type(in_type), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_type(out_type64), .out_tag(out_tag64)
  );

  // Clock and initial reset level.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference extension from a full 32-bit instruction word.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] t);
    case (t)
      ITYPE:   ref_imm = {{52{i[31]}}, i[31:20]};
      STYPE:   ref_imm = {{52{i[31]}}, i[31:25], i[11:7]};
      BTYPE:   ref_imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      UTYPE:   ref_imm = {{32{i[31]}}, i[31:12], 12'h000};
      JTYPE:   ref_imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      CSRTYPE: ref_imm = {59'd0, i[19:15]};
      default: ref_imm = 64'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [2:0] t,
                       input logic [31:0] tag, input logic [63:0] e);
    in_valid = 1'b1;
    in_inst  = inst[31:7];
    in_type  = t;
    in_tag   = tag;
    drv_exp  = e;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Scoreboard: push on accept, pop and compare on drain (sampled mid-cycle).
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid32 && out_ready) begin
        chk("sb_output_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_valid64", out_valid64, 1);
          chk("sb_imm64", out_imm64, e[98:35]);
          chk("sb_imm32", out_imm32, e[66:35]);
          chk("sb_type32", out_type32, e[34:32]);
          chk("sb_type64", out_type64, e[34:32]);
          chk("sb_tag32", out_tag32, e[31:0]);
          chk("sb_tag64", out_tag64, e[31:0]);
        end
      end
      if (flush) exp_q.delete();
      else if (in_valid && in_ready32) exp_q.push_back({drv_exp, in_type, in_tag});
    end
  end

  initial begin
    logic [31:0] ri;
    logic [2:0]  rt;
    logic        rdy;
    int          guard;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_type = '0;
    in_tag = '0; out_ready = 1'b0; drv_exp = '0;

    // Reset state.
    step(); step();
    chk("rst_in_ready", in_ready32, 0);
    chk("rst_out_valid", out_valid32, 0);
    chk("rst_out_imm", out_imm64, 0);
    chk("rst_out_tag", out_tag32, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready32, 1);

    // Single ITYPE with 1-cycle latency.
    out_ready = 1'b1;
    drive(32'hFFF00093, ITYPE, 32'h0000_1000, 64'hFFFF_FFFF_FFFF_FFFF);
    step(); idle();
    chk("lat_valid", out_valid32, 1);
    chk("lat_imm32", out_imm32, 32'hFFFF_FFFF);
    chk("lat_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    step();

    // Back-to-back directed vectors at full throughput.
    drive(32'hFE000EE3, BTYPE, 32'h0000_1004, 64'hFFFF_FFFF_FFFF_FFFC); step();
    drive(32'h0010006F, JTYPE, 32'h0000_1008, 64'h0000_0000_0000_0800); step();
    drive(32'h000F8073, CSRTYPE, 32'h0000_100C, 64'h0000_0000_0000_001F); step();
    drive(32'h00B50533, RTYPE, 32'h0000_1010, 64'h0); step();
    drive(32'h800000B7, UTYPE, 32'h0000_1014, 64'hFFFF_FFFF_8000_0000); step();
    drive(32'hFE512C23, STYPE, 32'h0000_1018, 64'hFFFF_FFFF_FFFF_FFF8); step();
    drive(32'hFFFFFFFF, 3'd7, 32'h0000_101C, 64'h0); step();
    chk("stream_in_ready", in_ready32, 1);
    idle(); step(); step();

    // Backpressure: A to main, B to skid, C refused until space returns.
    out_ready = 1'b0;
    drive(32'h00100093, ITYPE, 32'hAAAA_0001, 64'h1); step();
    drive(32'h00200093, ITYPE, 32'hBBBB_0002, 64'h2); step();
    drive(32'h00300093, ITYPE, 32'hCCCC_0003, 64'h3);
    chk("bp_in_ready_low", in_ready32, 0);
    chk("bp_main_tag", out_tag32, 32'hAAAA_0001);
    step();
    chk("bp_hold_tag", out_tag32, 32'hAAAA_0001);
    chk("bp_hold_imm", out_imm32, 32'h1);
    out_ready = 1'b1;
    step();
    guard = 0;
    while (!in_ready32 && guard < 20) begin step(); guard++; end
    chk("bp_ready_returns", in_ready32, 1);
    step(); idle();
    step(); step();
    chk("bp_drained", exp_q.size(), 0);

    // Flush with main and skid full and an input offered.
    out_ready = 1'b0;
    drive(32'h00400093, ITYPE, 32'hDDDD_0004, 64'h4); step();
    drive(32'h00500093, ITYPE, 32'hEEEE_0005, 64'h5); step();
    drive(32'h00600093, ITYPE, 32'hFFFF_0006, 64'h6);
    flush = 1'b1;
    step();
    flush = 1'b0; idle();
    chk("fl_out_valid", out_valid32, 0);
    chk("fl_in_ready", in_ready32, 1);
    // Flush discarding a same-cycle accept.
    drive(32'h00700093, ITYPE, 32'h1111_0007, 64'h7); step();
    drive(32'h00800093, ITYPE, 32'h2222_0008, 64'h8);
    flush = 1'b1;
    step();
    flush = 1'b0; idle();
    chk("fl2_out_valid", out_valid32, 0);
    out_ready = 1'b1;
    step(); step(); step();
    chk("fl_no_output", out_valid32, 0);

    // Asynchronous reset between edges while holding data.
    out_ready = 1'b0;
    drive(32'h00900093, ITYPE, 32'h3333_0009, 64'h9); step(); idle();
    chk("pre_rst_valid", out_valid32, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid32, 0);
    chk("arst_out_imm", out_imm32, 0);
    chk("arst_out_tag", out_tag32, 0);
    chk("arst_in_ready", in_ready32, 0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready32, 1);
    out_ready = 1'b1;
    drive(32'h80000093, ITYPE, 32'h4444_000A, 64'hFFFF_FFFF_FFFF_F800); step(); idle();
    chk("post_rst_valid", out_valid32, 1);
    chk("post_rst_imm", out_imm32, 32'hFFFF_F800);
    step();

    // Random instructions with random backpressure.
    for (int k = 0; k < 24; k++) begin
      ri = $urandom();
      rt = 3'($urandom_range(0, 7));
      drive(ri, rt, 32'h5000_0000 + k, ref_imm(ri, rt));
      guard = 0;
      rdy = 1'b0;
      while (!rdy && guard < 20) begin
        rdy = in_ready32;
        out_ready = 1'($urandom_range(0, 1));
        step();
        guard++;
      end
      chk("rnd_accepted", rdy, 1);
    end
    idle();
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin step(); guard++; end
    step();
    chk("final_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
